// File: rtl/cache_axi_rd_arbiter_if.sv
// AXI read channel (AR + R) bundle shared between the cache read arbiter
// and the downstream interconnect.
//   master : driven by the arbiter (AR request, R ready)
//   slave  : driven by the interconnect/memory (AR ready, R beats)
interface cache_axi_rd_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/cache_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between the icache and
// dcache read ports. One transaction outstanding at a time: line requests
// become 8-beat INCR bursts, uncached requests single-beat reads; beats are
// assembled into a 256-bit buffer returned with a one-cycle ret_valid pulse.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_rd_* / i_ret_*    icache request / return handshake
//   d_rd_* / d_ret_*    dcache request / return handshake
//   axi                 AXI read channel (master side)
module cache_axi_rd_arbiter #(
    parameter logic [3:0] IC_ARID = 4'd0,
    parameter logic [3:0] DC_ARID = 4'd1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_rd_req,
    input  logic                         i_rd_type,
    input  logic [31:0]                  i_rd_addr,
    output logic                         i_rd_rdy,
    output logic                         i_ret_valid,
    output logic [255:0]                 i_ret_data,
    input  logic                         d_rd_req,
    input  logic                         d_rd_type,
    input  logic [31:0]                  d_rd_addr,
    output logic                         d_rd_rdy,
    output logic                         d_ret_valid,
    output logic [255:0]                 d_ret_data,
    cache_axi_rd_arbiter_if.master       axi
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RET
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic           owner_dc;       // 1 = dcache owns the current transaction
    logic [31:0]    addr_q;
    logic           type_q;         // 1 = line, 0 = uncached word
    logic           last_grant_dc;  // 1 = dcache was granted last
    logic [255:0]   line_buf;
    logic [2:0]     beat_cnt;

    logic           grant_dc;
    logic           hs;
    logic           beat;

    // Arbitration: a lone requester wins; on contention the side that was
    // not granted last time wins.
    always_comb begin
        grant_dc = 1'b0;
        if (i_rd_req && d_rd_req) begin
            grant_dc = ~last_grant_dc;
        end else begin
            grant_dc = d_rd_req;
        end
    end

    always_comb begin
        i_rd_rdy = 1'b0;
        d_rd_rdy = 1'b0;
        if (state == S_IDLE) begin
            i_rd_rdy = i_rd_req && !grant_dc;
            d_rd_rdy = d_rd_req &&  grant_dc;
        end
    end

    assign hs   = (i_rd_req && i_rd_rdy) || (d_rd_req && d_rd_rdy);
    assign beat = (state == S_R) && axi.rvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (hs)                       state_nxt = S_AR;
            S_AR:   if (axi.arready)              state_nxt = S_R;
            S_R:    if (axi.rvalid && axi.rlast)  state_nxt = S_RET;
            S_RET:                                state_nxt = S_IDLE;
            default:                              state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_dc      <= 1'b0;
            addr_q        <= '0;
            type_q        <= 1'b0;
            last_grant_dc <= 1'b0;
            line_buf      <= '0;
            beat_cnt      <= '0;
        end else begin
            if (state == S_IDLE && hs) begin
                owner_dc      <= grant_dc;
                addr_q        <= grant_dc ? d_rd_addr : i_rd_addr;
                type_q        <= grant_dc ? d_rd_type : i_rd_type;
                last_grant_dc <= grant_dc;
                line_buf      <= '0;
                beat_cnt      <= '0;
            end
            if (beat) begin
                // Counter saturates at 7 so any overrun beats land in word 7.
                line_buf[{beat_cnt, 5'd0} +: 32] <= axi.rdata;
                if (beat_cnt != 3'd7) begin
                    beat_cnt <= beat_cnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        axi.arid    = owner_dc ? DC_ARID : IC_ARID;
        axi.araddr  = addr_q;
        axi.arlen   = type_q ? 8'd7 : 8'd0;
        axi.arsize  = 3'b010;
        axi.arburst = 2'b01;
        axi.arvalid = (state == S_AR);
        axi.rready  = (state == S_R);
    end

    assign i_ret_valid = (state == S_RET) && !owner_dc;
    assign d_ret_valid = (state == S_RET) &&  owner_dc;
    assign i_ret_data  = line_buf;
    assign d_ret_data  = line_buf;

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
module tb_cache_axi_rd_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_rd_req, i_rd_type, i_rd_rdy, i_ret_valid;
    logic [31:0]  i_rd_addr;
    logic [255:0] i_ret_data;
    logic         d_rd_req, d_rd_type, d_rd_rdy, d_ret_valid;
    logic [31:0]  d_rd_addr;
    logic [255:0] d_ret_data;

    int checks = 0;
    int failures = 0;

    cache_axi_rd_arbiter_if axi ();

    cache_axi_rd_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .i_rd_req    (i_rd_req),
        .i_rd_type   (i_rd_type),
        .i_rd_addr   (i_rd_addr),
        .i_rd_rdy    (i_rd_rdy),
        .i_ret_valid (i_ret_valid),
        .i_ret_data  (i_ret_data),
        .d_rd_req    (d_rd_req),
        .d_rd_type   (d_rd_type),
        .d_rd_addr   (d_rd_addr),
        .d_rd_rdy    (d_rd_rdy),
        .d_ret_valid (d_ret_valid),
        .d_ret_data  (d_ret_data),
        .axi         (axi)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AR handshake after `delay` cycles of arready low.
    task automatic accept_ar(input int delay);
        axi.arready = 1'b0;
        repeat (delay) tick();
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
    endtask

    // One R beat preceded by `gap` idle cycles.
    task automatic send_beat(input logic [31:0] data, input logic last, input int gap);
        axi.rvalid = 1'b0;
        repeat (gap) tick();
        axi.rvalid = 1'b1;
        axi.rdata  = data;
        axi.rlast  = last;
        tick();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0) begin
            failures++;
            $display("FAIL reset_axi arvalid=%b rready=%b exp 0 0", axi.arvalid, axi.rready);
        end
        checks++;
        if (i_ret_valid !== 1'b0 || d_ret_valid !== 1'b0 || i_rd_rdy !== 1'b0 || d_rd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl iret=%b dret=%b irdy=%b drdy=%b exp 0000",
                     i_ret_valid, d_ret_valid, i_rd_rdy, d_rd_rdy);
        end
        checks++;
        if (i_ret_data !== 256'd0) begin
            failures++;
            $display("FAIL reset_buf got=%h exp=0", i_ret_data);
        end
    endtask

    task automatic test_icache_line();
        logic [255:0] exp;
        exp = '0;
        tick();
        i_rd_req = 1'b1; i_rd_type = 1'b1; i_rd_addr = 32'h1FC0_0020;
        #1;
        checks++;
        if (i_rd_rdy !== 1'b1 || d_rd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL ic_rdy irdy=%b drdy=%b exp 1 0", i_rd_rdy, d_rd_rdy);
        end
        tick();
        i_rd_req = 1'b0;
        #1;
        checks++;
        if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h1FC0_0020 || axi.arlen !== 8'd7 || axi.arid !== 4'd0) begin
            failures++;
            $display("FAIL ic_ar arvalid=%b araddr=%h arlen=%0d arid=%0d exp 1 1fc00020 7 0",
                     axi.arvalid, axi.araddr, axi.arlen, axi.arid);
        end
        checks++;
        if (axi.arsize !== 3'b010 || axi.arburst !== 2'b01) begin
            failures++;
            $display("FAIL ic_arconst arsize=%b arburst=%b exp 010 01", axi.arsize, axi.arburst);
        end
        accept_ar(0);
        #1;
        checks++;
        if (axi.arvalid !== 1'b0 || axi.rready !== 1'b1) begin
            failures++;
            $display("FAIL ic_rphase arvalid=%b rready=%b exp 0 1", axi.arvalid, axi.rready);
        end
        for (int k = 0; k < 8; k++) begin
            send_beat(32'(k), (k == 7), 0);
            exp[k*32 +: 32] = 32'(k);
        end
        #1;
        checks++;
        if (i_ret_valid !== 1'b1 || d_ret_valid !== 1'b0) begin
            failures++;
            $display("FAIL ic_ret iret=%b dret=%b exp 1 0", i_ret_valid, d_ret_valid);
        end
        checks++;
        if (i_ret_data !== exp) begin
            failures++;
            $display("FAIL ic_data got=%h exp=%h", i_ret_data, exp);
        end
        tick();
        #1;
        checks++;
        if (i_ret_valid !== 1'b0) begin
            failures++;
            $display("FAIL ic_ret_pulse iret=%b exp 0", i_ret_valid);
        end
    endtask

    task automatic test_dcache_uncached();
        d_rd_req = 1'b1; d_rd_type = 1'b0; d_rd_addr = 32'hBFAF_8000;
        #1;
        checks++;
        if (d_rd_rdy !== 1'b1 || i_rd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL dc_rdy drdy=%b irdy=%b exp 1 0", d_rd_rdy, i_rd_rdy);
        end
        tick();
        d_rd_req = 1'b0;
        #1;
        checks++;
        if (axi.arvalid !== 1'b1 || axi.araddr !== 32'hBFAF_8000 || axi.arlen !== 8'd0 || axi.arid !== 4'd1) begin
            failures++;
            $display("FAIL dc_ar arvalid=%b araddr=%h arlen=%0d arid=%0d exp 1 bfaf8000 0 1",
                     axi.arvalid, axi.araddr, axi.arlen, axi.arid);
        end
        accept_ar(0);
        send_beat(32'hDEAD_BEEF, 1'b1, 0);
        #1;
        checks++;
        if (d_ret_valid !== 1'b1 || i_ret_valid !== 1'b0) begin
            failures++;
            $display("FAIL dc_ret dret=%b iret=%b exp 1 0", d_ret_valid, i_ret_valid);
        end
        checks++;
        if (d_ret_data !== {224'd0, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL dc_data got=%h exp=%h", d_ret_data, {224'd0, 32'hDEAD_BEEF});
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic got_dc;
        logic found;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_rd_req = 1'b1; i_rd_type = 1'b0; i_rd_addr = 32'h0000_0100;
        d_rd_req = 1'b1; d_rd_type = 1'b0; d_rd_addr = 32'h0000_0200;
        for (int t = 0; t < 4; t++) begin
            found  = 1'b0;
            got_dc = 1'b0;
            for (int w = 0; w < 10 && !found; w++) begin
                #1;
                checks++;
                if (i_rd_rdy === 1'b1 && d_rd_rdy === 1'b1) begin
                    failures++;
                    $display("FAIL rr_both_rdy irdy=1 drdy=1 exp at most one");
                end
                if (i_rd_rdy === 1'b1 || d_rd_rdy === 1'b1) begin
                    found  = 1'b1;
                    got_dc = d_rd_rdy;
                end else begin
                    tick();
                end
            end
            checks++;
            if (!found) begin
                failures++;
                $display("FAIL rr_timeout txn=%0d no rd_rdy within 10 cycles", t);
            end else if (got_dc !== ((t % 2) == 0)) begin
                failures++;
                $display("FAIL rr_order txn=%0d got_dc=%b exp_dc=%b", t, got_dc, ((t % 2) == 0));
            end
            if (!found) break;
            tick();
            #1;
            checks++;
            if (axi.arid !== (((t % 2) == 0) ? 4'd1 : 4'd0) || axi.araddr !== (((t % 2) == 0) ? 32'h200 : 32'h100)) begin
                failures++;
                $display("FAIL rr_ar txn=%0d arid=%0d araddr=%h", t, axi.arid, axi.araddr);
            end
            accept_ar(0);
            send_beat(32'(t + 16), 1'b1, 0);
            #1;
            checks++;
            if (d_ret_valid !== ((t % 2) == 0) || i_ret_valid !== ((t % 2) == 1)
                || i_rd_rdy !== 1'b0 || d_rd_rdy !== 1'b0) begin
                failures++;
                $display("FAIL rr_ret txn=%0d dret=%b iret=%b irdy=%b drdy=%b",
                         t, d_ret_valid, i_ret_valid, i_rd_rdy, d_rd_rdy);
            end
            tick();
        end
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
    endtask

    task automatic test_stall_gap();
        logic [255:0] exp;
        exp = '0;
        i_rd_req = 1'b1; i_rd_type = 1'b1; i_rd_addr = 32'h0000_1000;
        tick();
        i_rd_req = 1'b0;
        i_rd_addr = 32'hFFFF_FFE0;
        axi.arready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h0000_1000 || axi.arlen !== 8'd7) begin
                failures++;
                $display("FAIL stall_ar cyc=%0d arvalid=%b araddr=%h arlen=%0d exp 1 00001000 7",
                         c, axi.arvalid, axi.araddr, axi.arlen);
            end
            tick();
        end
        accept_ar(0);
        for (int k = 0; k < 8; k++) begin
            send_beat(32'hA000_0000 + 32'(k), (k == 7), 3);
            exp[k*32 +: 32] = 32'hA000_0000 + 32'(k);
        end
        #1;
        checks++;
        if (i_ret_valid !== 1'b1 || i_ret_data !== exp) begin
            failures++;
            $display("FAIL gap_data iret=%b got=%h exp=%h", i_ret_valid, i_ret_data, exp);
        end
        tick();
    endtask

    task automatic test_early_rlast();
        logic [255:0] exp;
        exp = '0;
        d_rd_req = 1'b1; d_rd_type = 1'b1; d_rd_addr = 32'h0000_2000;
        tick();
        d_rd_req = 1'b0;
        accept_ar(0);
        send_beat(32'h11, 1'b0, 0);
        send_beat(32'h22, 1'b0, 0);
        send_beat(32'h33, 1'b1, 0);
        exp[31:0]  = 32'h11;
        exp[63:32] = 32'h22;
        exp[95:64] = 32'h33;
        #1;
        checks++;
        if (d_ret_valid !== 1'b1 || d_ret_data !== exp) begin
            failures++;
            $display("FAIL early_rlast dret=%b got=%h exp=%h", d_ret_valid, d_ret_data, exp);
        end
        tick();
        #1;
        checks++;
        if (d_ret_valid !== 1'b0 || axi.rready !== 1'b0 || axi.arvalid !== 1'b0) begin
            failures++;
            $display("FAIL early_idle dret=%b rready=%b arvalid=%b exp 0 0 0",
                     d_ret_valid, axi.rready, axi.arvalid);
        end
    endtask

    task automatic test_reset_mid();
        i_rd_req = 1'b1; i_rd_type = 1'b1; i_rd_addr = 32'h0000_3000;
        tick();
        i_rd_req = 1'b0;
        accept_ar(0);
        for (int k = 0; k < 4; k++) send_beat(32'h55 + 32'(k), 1'b0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (axi.rready !== 1'b0 || axi.arvalid !== 1'b0 || i_ret_valid !== 1'b0 || i_ret_data !== 256'd0) begin
            failures++;
            $display("FAIL mid_reset rready=%b arvalid=%b iret=%b buf=%h exp 0 0 0 0",
                     axi.rready, axi.arvalid, i_ret_valid, i_ret_data);
        end
        i_rd_req = 1'b1; i_rd_type = 1'b0; i_rd_addr = 32'h0000_4000;
        #1;
        checks++;
        if (i_rd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_rdy irdy=%b exp 1", i_rd_rdy);
        end
        tick();
        i_rd_req = 1'b0;
        accept_ar(0);
        send_beat(32'hCAFE_0001, 1'b1, 0);
        #1;
        checks++;
        if (i_ret_valid !== 1'b1 || i_ret_data !== {224'd0, 32'hCAFE_0001}) begin
            failures++;
            $display("FAIL post_reset_data iret=%b got=%h exp=%h",
                     i_ret_valid, i_ret_data, {224'd0, 32'hCAFE_0001});
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        i_rd_req = 1'b0; i_rd_type = 1'b0; i_rd_addr = '0;
        d_rd_req = 1'b0; d_rd_type = 1'b0; d_rd_addr = '0;
        axi.arready = 1'b0;
        axi.rid     = '0;
        axi.rdata   = '0;
        axi.rresp   = '0;
        axi.rlast   = 1'b0;
        axi.rvalid  = 1'b0;
        test_reset();
        test_icache_line();
        test_dcache_uncached();
        test_round_robin();
        test_stall_gap();
        test_early_rlast();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_axi_rd_arbiter.md
Name: cache_axi_rd_arbiter

Overview:
- Shares one AXI read channel (AR/R, 32-bit data) between the icache and the dcache refill/uncached read ports.
- Each side uses the cache-side handshake `rd_req`/`rd_type`/`rd_addr`/`rd_rdy`/`ret_valid`/`ret_data`.
- Round-robin arbitration, one outstanding transaction. Converts line requests into 8-beat INCR bursts and assembles the beats into a 256-bit line returned in one pulse.

Parameters:
IC_ARID, 4'd0, ARID driven for icache-owned transactions
DC_ARID, 4'd1, ARID driven for dcache-owned transactions

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_rd_req  in  1  icache read request
i_rd_type  in  1  0 = uncached single word, 1 = cache line
i_rd_addr  in  32  icache request address (line requests have [4:0]=0)
i_rd_rdy  out  1  icache request accepted this cycle
i_ret_valid  out  1  one-cycle pulse: icache data valid
i_ret_data  out  256  returned line/word
d_rd_req, d_rd_type, d_rd_addr, d_rd_rdy, d_ret_valid, d_ret_data  same as i_* for the dcache
arid  out  4  owner ID
araddr  out  32  burst address
arlen  out  8  7 for line, 0 for uncached
arsize  out  3  constant 3'b010
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  ignored (single outstanding)
rdata  in  32  read beat
rresp  in  2  ignored
rlast  in  1  last beat
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Clock is `clk`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - State IDLE.
  - `arvalid`, `rready`, `i_rd_rdy`, `d_rd_rdy`, `i_ret_valid`, `d_ret_valid` = 0.
  - Line buffer = 0; beat counter = 0; `last_grant` = icache.
- States: IDLE, AR, R, RET (one-hot or encoded).
- IDLE:
  - `x_rd_rdy` is combinational: asserted only for the requester picked by arbitration, and only in IDLE.
  - The handshake completes when `x_rd_req && x_rd_rdy`.
  - Arbitration: with only one requester, grant it. With both, grant the one not equal to `last_grant`.
  - On handshake: latch owner, addr and type; update `last_grant`; clear the line buffer and beat counter; go to AR.
  - No handshake: stay in IDLE.
- AR:
  - `arvalid` = 1, with `araddr`/`arlen`/`arid` from latched values, held stable until `arready`.
  - `arvalid && arready` -> R (the next cycle drives `arvalid` = 0).
- R:
  - `rready` = 1.
  - Each `rvalid && rready` beat k writes `rdata` to buffer [32k+31:32k]; the counter increments and saturates at 7.
  - Beats after the counter saturates overwrite word 7.
  - Uncached: the single beat goes to [31:0]; [255:32] stays 0.
  - Accepted beat with `rlast` = 1 -> RET, regardless of beat count. An early `rlast` leaves unfilled words at 0.
- RET:
  - The owner's `x_ret_valid` = 1 for exactly one cycle. The other side's `ret_valid` stays 0.
  - `i_ret_data` and `d_ret_data` are both driven from the buffer continuously.
  - Next state is IDLE. No new grant is issued in RET.
- Latency:
  - Request handshake to `arvalid`: 1 cycle.
  - Last beat to `ret_valid`: 1 cycle.
  - `ret_valid` to next `rd_rdy`: 1 cycle minimum.
- Address/type changes while `rd_req` is high without `rd_rdy` are allowed; only values at the handshake cycle are used.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. Any in-flight AXI burst is abandoned; the interconnect is reset concurrently.
- `rvalid` outside R is not accepted (`rready` = 0).

Test Plan:
- icache line request, `addr` = 0x1FC0_0020 -> next cycle `arvalid` = 1, `araddr` = 0x1FC0_0020, `arlen` = 7, `arid` = 0. Beats 0x0..0x7, with `rlast` on beat 8 -> one-cycle `i_ret_valid`, `i_ret_data` = {32'h7, …, 32'h0}, `d_ret_valid` = 0.
- dcache uncached read, `addr` = 0xBFAF_8000, `rdata` = 0xDEADBEEF -> `arlen` = 0, `arid` = 1, `d_ret_data` = {224'b0, 32'hDEADBEEF}.
- Both `rd_req` high every cycle for 4 transactions from reset -> grant order dcache, icache, dcache, icache; the non-granted `rd_rdy` is never high.
- `arready` held low 5 cycles -> `arvalid`, `araddr`, `arlen` stable for 5 cycles. `rvalid` gaps of 3 cycles between beats -> the line is still assembled correctly.
- `rlast` on beat 3 of a line burst -> `ret_valid` next cycle, words 3..7 = 0, then IDLE.
- `reset` pulsed during R after beat 4 -> next cycle `rready` = 0, `arvalid` = 0, no `ret_valid`. A new icache request is then accepted normally with a cleared buffer.
